text_line_ctrl: RTL
===================

// Module: text_line_ctrl
// PURPOSE
//  Owns the 30-character text line shown in the on-screen status strip.
//  Two requesters (e.g. game logic, UART command path) write character codes
//  through a round-robin arbiter; a clear request blanks the line.
//  Buffer updates are held off while the strip is being scanned (tear-free).
//  Serves the text drawer's char_xy lookups with the character code, which
//  feeds the font ROM address.
// PARAMETERS
//  NCHARS   30     characters per line (char_xy range 0..NCHARS-1)
//  RECT_Y   464    first scanline of the text strip
//  RECT_H   16     strip height in scanlines
//  SPACE    7'h20  code written by clear / returned for out-of-range reads
// PORTS
//  pclk       in   1   pixel clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  vcount_in  in   11  current scanline from vga timing
//  char_xy    in   5   character index requested by the text drawer
//  char_code  out  7   code at char_xy, registered
//  wr_req     in   2   per-requester write request, held until ack
//  wr_addr0/1 in   5   target index for requester 0/1
//  wr_char0/1 in   7   character code for requester 0/1
//  wr_ack     out  2   one-cycle ack per requester
//  wr_err     out  1   one-cycle pulse: acked write had addr >= NCHARS
//  clr_req    in   1   clear-line request, held until clr_ack
//  clr_ack    out  1   one-cycle pulse when the clear sweep finishes
//  busy       out  1   high while the FSM is not IDLE
// BEHAVIOUR
//  Reset: char_code=SPACE, wr_ack=0, wr_err=0, clr_ack=0, busy=1.
//   Round-robin pointer is set to requester 0. FSM goes to CLEAR at index 0.
//  blank_ok = !(vcount_in >= RECT_Y && vcount_in < RECT_Y+RECT_H).
//   Buffer writes happen only on cycles where blank_ok=1.
//  Read path: char_code <= (char_xy<NCHARS) ? buf[char_xy] : SPACE.
//   Latency is 1 cycle and independent of FSM state.
//   A same-cycle write to the read address returns the old value.
//  FSM states:
//   IDLE  - clr_req -> CLEAR (idx=0). Clear has priority over writes.
//           Otherwise if any wr_req -> GRANT; the arbiter picks requester g.
//   GRANT - waits here while !blank_ok. When blank_ok: buf[addr_g]<=char_g
//           if addr_g<NCHARS, else pulse wr_err. Pulse wr_ack[g], toggle RR
//           pointer to !g, go to IDLE.
//   CLEAR - when blank_ok: buf[idx]<=SPACE, idx++. When !blank_ok: stall,
//           keeping idx. After idx==NCHARS-1 is written -> IDLE and pulse
//           clr_ack, except for the post-reset sweep (no clr_ack).
//  Arbiter: if only one wr_req is set, that requester wins. If both are set,
//   the requester at the RR pointer wins. Address and data are sampled on the
//   grant cycle. Requester drops wr_req the cycle after wr_ack; the block
//   ignores wr_req for one cycle after an ack to avoid a double grant.
//  A write costs >= 2 cycles (IDLE->GRANT->IDLE), so acks never occur on
//   consecutive cycles.
//  rst mid-GRANT or mid-CLEAR: any pending ack is dropped; restart at CLEAR
//   index 0. A clr_req arriving during GRANT is served after the write completes.
// STRUCTURE
//  text_pkg: NCHARS, RECT_Y, RECT_H, SPACE_CODE, FSM state encoding.
//   The text drawer uses the same RECT_Y/RECT_H/NCHARS constants.
//  Sub-module rr_arbiter2: 2-way round robin, inputs req[1:0] and advance,
//   outputs grant[1:0], pointer register inside.
//  Buffer: NCHARS x 7 register array (distributed RAM, async read + output reg).
// TESTING
//  1. Release rst at vcount=0 -> busy=1 for 30 cycles, then 0; all char_code
//     reads = 7'h20; no clr_ack.
//  2. wr_req[0], addr0=5, char0=7'h41, vcount=100 -> wr_ack[0] 2 cycles later;
//     char_xy=5 reads 7'h41 one cycle after the read is presented.
//  3. Same write issued at vcount=470 -> no ack until vcount=480, then ack;
//     buffer unchanged while scanning the strip.
//  4. Both wr_req held continuously -> acks alternate 0,1,0,1; each requester
//     gets at least 1 ack per 2 writes.
//  5. clr_req together with wr_req[1] in IDLE -> clear runs first; clr_ack after
//     30 blank cycles; then wr_ack[1]. A clear that enters vcount 464 stalls
//     and resumes at 480.
//  6. addr1=31 write -> wr_ack[1] and wr_err pulse together, buffer unchanged;
//     char_xy=31 read -> 7'h20.

Source files
------------

// File: rtl/text_line_ctrl_pkg.sv
// Shared constants for the status-strip text line: geometry, blank code, FSM encoding.
// The text drawer imports the same geometry so both sides agree on the strip.
package text_line_ctrl_pkg;

    localparam int NCHARS = 30;
    localparam int RECT_Y = 464;
    localparam int RECT_H = 16;
    localparam int AW     = 5;
    localparam int CW     = 7;
    localparam int VW     = 11;

    localparam logic [CW-1:0] SPACE_CODE = 7'h20;
    localparam logic [AW-1:0] NCH_A      = AW'(NCHARS);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NCHARS - 1);
    localparam logic [VW-1:0] STRIP_LO   = VW'(RECT_Y);
    localparam logic [VW-1:0] STRIP_HI   = VW'(RECT_Y + RECT_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Buffer may only change outside the scanned strip.
    function automatic logic blank_window(input logic [VW-1:0] v);
        return !(v >= STRIP_LO && v < STRIP_HI);
    endfunction

endpackage

// File: rtl/text_line_ctrl_if.sv
// Write/clear handshake between the requesters (master) and the text line block (slave).
interface text_line_ctrl_if;
    import text_line_ctrl_pkg::*;

    logic [1:0]    wr_req;
    logic [AW-1:0] wr_addr0;
    logic [AW-1:0] wr_addr1;
    logic [CW-1:0] wr_char0;
    logic [CW-1:0] wr_char1;
    logic [1:0]    wr_ack;
    logic          wr_err;
    logic          clr_req;
    logic          clr_ack;
    logic          busy;

    modport master (
        output wr_req, wr_addr0, wr_addr1, wr_char0, wr_char1, clr_req,
        input  wr_ack, wr_err, clr_ack, busy
    );

    modport slave (
        input  wr_req, wr_addr0, wr_addr1, wr_char0, wr_char1, clr_req,
        output wr_ack, wr_err, clr_ack, busy
    );

endinterface

// File: rtl/text_line_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names who wins a tie and moves past
// the winner whenever a grant is taken.
module text_line_ctrl_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (advance)
            ptr <= grant[0];
    end

endmodule

// File: rtl/text_line_ctrl.sv
// 30-character status line buffer: arbitrated writes, clear sweep, tear-free
// updates outside the scanned strip, and a registered read port for the drawer.
module text_line_ctrl
    import text_line_ctrl_pkg::*;
(
    input  logic          pclk,
    input  logic          rst,
    input  logic [VW-1:0] vcount_in,
    input  logic [AW-1:0] char_xy,
    output logic [CW-1:0] char_code,
    text_line_ctrl_if.slave wif
);

    state_t        state;
    logic [AW-1:0] idx;
    logic          post_reset;
    logic          g_sel;
    logic [AW-1:0] g_addr;
    logic [CW-1:0] g_char;
    logic [1:0]    ack_q;
    logic          err_q;
    logic          clr_ack_q;
    logic          busy_q;

    logic [CW-1:0] line_mem [NCHARS];

    logic          blank_ok;
    logic          ack_hold;
    logic [1:0]    req_eff;
    logic [1:0]    grant;
    logic          clr_go;
    logic          take;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [CW-1:0] mem_wdata;

    assign blank_ok = blank_window(vcount_in);

    // Requesters still hold their request in the cycle an ack is visible;
    // masking that cycle prevents a second grant of the same request.
    assign ack_hold = (|ack_q) | clr_ack_q;
    assign req_eff  = ack_hold ? 2'b00 : wif.wr_req;
    assign clr_go   = (state == ST_IDLE) && wif.clr_req && !ack_hold;
    assign take     = (state == ST_IDLE) && !wif.clr_req && (|req_eff);

    text_line_ctrl_rr_arbiter2 u_rr_arbiter2 (
        .clk     (pclk),
        .rst     (rst),
        .req     (req_eff),
        .advance (take),
        .grant   (grant)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = g_addr;
        mem_wdata = g_char;
        if (!rst && blank_ok) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = idx;
                mem_wdata = SPACE_CODE;
            end else if (state == ST_GRANT && g_addr < NCH_A) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (mem_we)
            line_mem[mem_waddr] <= mem_wdata;
    end

    // Old contents win on a same-cycle write to the read address.
    always_ff @(posedge pclk) begin
        if (rst)
            char_code <= SPACE_CODE;
        else
            char_code <= (char_xy < NCH_A) ? line_mem[char_xy] : SPACE_CODE;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            idx        <= '0;
            post_reset <= 1'b1;
            g_sel      <= 1'b0;
            g_addr     <= '0;
            g_char     <= '0;
            ack_q      <= 2'b00;
            err_q      <= 1'b0;
            clr_ack_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            ack_q     <= 2'b00;
            err_q     <= 1'b0;
            clr_ack_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (clr_go) begin
                        state  <= ST_CLEAR;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end else if (take) begin
                        state  <= ST_GRANT;
                        g_sel  <= grant[1];
                        g_addr <= grant[1] ? wif.wr_addr1 : wif.wr_addr0;
                        g_char <= grant[1] ? wif.wr_char1 : wif.wr_char0;
                        busy_q <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (blank_ok) begin
                        ack_q  <= g_sel ? 2'b10 : 2'b01;
                        err_q  <= !(g_addr < NCH_A);
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (blank_ok) begin
                        if (idx == LAST_IDX) begin
                            state      <= ST_IDLE;
                            busy_q     <= 1'b0;
                            clr_ack_q  <= !post_reset;
                            post_reset <= 1'b0;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign wif.wr_ack  = ack_q;
    assign wif.wr_err  = err_q;
    assign wif.clr_ack = clr_ack_q;
    assign wif.busy    = busy_q;

endmodule
